// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: op encodings, FSM states and op classification helpers.
package e_mdu_pkg;

    localparam int MDU_OP_W = 3;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic is_div(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_muldiv(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || is_div(op);
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage <-> MDU signal bundle; master is the pipeline, slave is the MDU.
interface e_mdu_if
    import e_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic                start;
    logic [MDU_OP_W-1:0] op;
    logic [WIDTH-1:0]    srcA;
    logic [WIDTH-1:0]    srcB;
    logic                cancel;
    logic                busy;
    logic                stall_req;
    logic                done;
    logic [WIDTH-1:0]    hi;
    logic [WIDTH-1:0]    lo;

    modport master (
        output start, op, srcA, srcB, cancel,
        input  busy, stall_req, done, hi, lo
    );

    modport slave (
        input  start, op, srcA, srcB, cancel,
        output busy, stall_req, done, hi, lo
    );

endinterface

// File: rtl/e_mdu_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; the first bit is
// produced on the start edge so results are ready WIDTH edges after start.
module e_mdu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]    count_q;

    logic [WIDTH-1:0] rem_in, quo_in, dvs_in;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_out, quo_out;

    always_comb begin
        rem_in = start ? '0 : rem_q;
        quo_in = start ? dividend : quo_q;
        dvs_in = start ? divisor : dvs_q;
        trial  = {rem_in, quo_in[WIDTH-1]};
        if (trial >= {1'b0, dvs_in}) begin
            rem_out = trial[WIDTH-1:0] - dvs_in;
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = trial[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            count_q <= '0;
        end else if (start) begin
            rem_q   <= rem_out;
            quo_q   <= quo_out;
            dvs_q   <= divisor;
            count_q <= CW'(1);
        end else if (count_q != CW'(WIDTH)) begin
            rem_q   <= rem_out;
            quo_q   <= quo_out;
            count_q <= count_q + CW'(1);
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign ready     = (count_q == CW'(WIDTH));

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with HI/LO registers and configurable latency.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 8
) (
    input logic   clk,
    input logic   reset,
    e_mdu_if.slave bus
);

    localparam bit USE_ITER = (DIV_CYCLES >= WIDTH);

    mdu_state_e state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] hi_q, lo_q, pend_hi, pend_lo;
    logic             pend_wr, p_div, q_neg, r_neg, done_q;

    logic             accept, mt_wr, commit, commit_ok, iter_sel;
    logic             a_neg, q_neg_in, r_neg_in;
    logic [WIDTH-1:0] mag_a, mag_b, q_c, r_c, div_q, div_r, hi_c, lo_c;
    logic             div_ready;
    logic [2*WIDTH-1:0] prod;

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    assign accept = (state == ST_IDLE) && bus.start && !bus.cancel && is_muldiv(bus.op);
    assign mt_wr  = (state == ST_IDLE) && bus.start && !bus.cancel &&
                    ((bus.op == MDU_MTHI) || (bus.op == MDU_MTLO));
    assign commit = (state == ST_BUSY) && !bus.cancel && (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_BUSY;
                    cnt_nxt   = is_div(bus.op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            ST_BUSY: begin
                if (bus.cancel || (cnt == CNT_W'(1))) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Signed division runs on magnitudes; quotient/remainder signs are restored afterwards.
    assign a_neg    = (bus.op == MDU_DIV) && bus.srcA[WIDTH-1];
    assign q_neg_in = (bus.op == MDU_DIV) && (bus.srcA[WIDTH-1] ^ bus.srcB[WIDTH-1]);
    assign r_neg_in = a_neg;
    assign mag_a    = a_neg ? (~bus.srcA + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.srcA;
    assign mag_b    = ((bus.op == MDU_DIV) && bus.srcB[WIDTH-1]) ?
                      (~bus.srcB + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.srcB;

    always_comb begin
        if (bus.op == MDU_MULT)
            prod = {{WIDTH{bus.srcA[WIDTH-1]}}, bus.srcA} * {{WIDTH{bus.srcB[WIDTH-1]}}, bus.srcB};
        else
            prod = {{WIDTH{1'b0}}, bus.srcA} * {{WIDTH{1'b0}}, bus.srcB};
    end

    generate
        if (USE_ITER) begin : g_iter
            e_mdu_divider #(.WIDTH(WIDTH)) u_div (
                .clk       (clk),
                .reset     (reset),
                .start     (accept && is_div(bus.op)),
                .dividend  (mag_a),
                .divisor   (mag_b),
                .quotient  (div_q),
                .remainder (div_r),
                .ready     (div_ready)
            );
            assign q_c = '0;
            assign r_c = '0;
        end else begin : g_comb
            logic [WIDTH-1:0] safe_b;
            assign safe_b    = (mag_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
            assign q_c       = apply_sign(mag_a / safe_b, q_neg_in);
            assign r_c       = apply_sign(mag_a % safe_b, r_neg_in);
            assign div_q     = '0;
            assign div_r     = '0;
            assign div_ready = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            p_div   <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
        end else if (accept) begin
            p_div   <= is_div(bus.op);
            q_neg   <= q_neg_in;
            r_neg   <= r_neg_in;
            pend_wr <= !(is_div(bus.op) && (mag_b == '0));
            if (is_div(bus.op)) begin
                pend_hi <= r_c;
                pend_lo <= q_c;
            end else begin
                {pend_hi, pend_lo} <= prod;
            end
        end
    end

    assign iter_sel  = USE_ITER && p_div;
    assign hi_c      = iter_sel ? apply_sign(div_r, r_neg) : pend_hi;
    assign lo_c      = iter_sel ? apply_sign(div_q, q_neg) : pend_lo;
    assign commit_ok = commit && pend_wr && (!iter_sel || div_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= commit;
            if (mt_wr) begin
                if (bus.op == MDU_MTHI) hi_q <= bus.srcA;
                else                    lo_q <= bus.srcA;
            end else if (commit_ok) begin
                hi_q <= hi_c;
                lo_q <= lo_c;
            end
        end
    end

    assign bus.busy      = (state == ST_BUSY);
    assign bus.stall_req = (state == ST_BUSY) || (bus.start && is_muldiv(bus.op));
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule
